// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the MEM stage: funct3 load/store encodings,
// FSM state encoding, access-size decode and the MEM_WB register bundle.
package riscv_mem_pkg;

  localparam int STRB_W = 32 / 8;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RD_WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [1:0]  mem2reg;
    logic        reg_write;
    logic [31:0] instr;
    logic [31:0] mem_data;
  } mem_wb_t;

  // Unknown load encodings are treated as full-word accesses.
  function automatic size_e access_size(input logic [2:0] funct3, input logic is_store);
    if (is_store) begin
      case (funct3)
        F3_SB:   return SZ_BYTE;
        F3_SH:   return SZ_HALF;
        F3_SW:   return SZ_WORD;
        default: return SZ_WORD;
      endcase
    end else begin
      case (funct3)
        F3_LB, F3_LBU: return SZ_BYTE;
        F3_LH, F3_LHU: return SZ_HALF;
        F3_LW:         return SZ_WORD;
        default:       return SZ_WORD;
      endcase
    end
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering: places store data/strobes on the lanes
// selected by the low address bits and extends the selected load lane.
module lsu_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]        funct3_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [31:0]       store_data_i,
  input  logic [31:0]       load_raw_i,
  output logic [31:0]       write_data_o,
  output logic [STRB_W-1:0] write_strb_o,
  output logic [31:0]       load_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = load_raw_i[{addr_lo_i, 3'b000} +: 8];
  assign ld_half = addr_lo_i[1] ? load_raw_i[31:16] : load_raw_i[15:0];

  // Replicate store data across lanes and enable only the addressed bytes.
  always_comb begin
    write_data_o = store_data_i;
    write_strb_o = 4'hF;
    unique case (access_size(funct3_i, 1'b1))
      SZ_BYTE: begin
        write_data_o = {4{store_data_i[7:0]}};
        write_strb_o = 4'b0001 << addr_lo_i;
      end
      SZ_HALF: begin
        write_data_o = {2{store_data_i[15:0]}};
        write_strb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
      end
      default: begin
        write_data_o = store_data_i;
        write_strb_o = 4'hF;
      end
    endcase
  end

  // Sign- or zero-extend the selected load lane; other encodings pass the word.
  always_comb begin
    load_data_o = load_raw_i;
    case (funct3_i)
      F3_LB:   load_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU:  load_data_o = {24'd0, ld_byte};
      F3_LH:   load_data_o = {{16{ld_half[15]}}, ld_half};
      F3_LHU:  load_data_o = {16'd0, ld_half};
      default: load_data_o = load_raw_i;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the data-memory req/ack handshake, waits for
// load data, and registers results into MEM_WB. Stalls upstream while an
// access is outstanding. Optional build macro MEM_MISALIGN_CHECK_EN rejects
// misaligned half/word accesses and adds the mem_misalign output.
module mem_access_stage
  import riscv_mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   EX_MEM_PC,
  input  logic [4:0]        EX_MEM_rd,
  input  logic [XLEN-1:0]   EX_MEM_ALU_Result,
  input  logic [XLEN-1:0]   EX_MEM_rdata2,
  input  logic              EX_MEM_MemRead,
  input  logic              EX_MEM_MemWrite,
  input  logic [1:0]        EX_MEM_Mem2Reg,
  input  logic              EX_MEM_RegWrite,
  input  logic [XLEN-1:0]   EX_MEM_Instr,
  output logic [XLEN-1:0]   Address,
  output logic              MemRead,
  output logic              MemWrite,
  output logic [XLEN-1:0]   Write_data,
  output logic [STRB_W-1:0] Write_strb,
  input  logic              Mem_Req_Ack,
  input  logic [XLEN-1:0]   Read_data,
  input  logic              Read_data_Valid,
  output logic              Read_data_Ready,
  output logic              mem_stall,
  output logic [XLEN-1:0]   MEM_WB_PC,
  output logic [4:0]        MEM_WB_rd,
  output logic [XLEN-1:0]   MEM_WB_ALU_Result,
  output logic [1:0]        MEM_WB_Mem2Reg,
  output logic              MEM_WB_RegWrite,
  output logic [XLEN-1:0]   MEM_WB_Instr,
  output logic [XLEN-1:0]   MEM_WB_Mem_Data
`ifdef MEM_MISALIGN_CHECK_EN
  ,
  output logic              mem_misalign
`endif
);

  state_e      state_q, state_d;
  mem_wb_t     wb_q, wb_d;
  logic        is_load, is_store, misaligned;
  logic        mem_read_c, mem_write_c, rd_ready_c, stall_c, misalign_c;
  logic [2:0]  funct3;
  logic [1:0]  addr_lo;
  logic [31:0] st_data, load_data;
  logic [3:0]  st_strb;

  // A request carrying both qualifiers is handled as a load.
  assign is_load  = EX_MEM_MemRead;
  assign is_store = EX_MEM_MemWrite & ~EX_MEM_MemRead;
  assign funct3   = EX_MEM_Instr[14:12];
  assign addr_lo  = EX_MEM_ALU_Result[1:0];

`ifdef MEM_MISALIGN_CHECK_EN
  size_e acc_size;
  assign acc_size   = access_size(funct3, is_store);
  assign misaligned = (is_load | is_store) &
                      (((acc_size == SZ_HALF) & addr_lo[0]) |
                       ((acc_size == SZ_WORD) & (addr_lo != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  lsu_align u_align (
    .funct3_i     (funct3),
    .addr_lo_i    (addr_lo),
    .store_data_i (EX_MEM_rdata2),
    .load_raw_i   (Read_data),
    .write_data_o (st_data),
    .write_strb_o (st_strb),
    .load_data_o  (load_data)
  );

  // Handshake sequencing: decide request qualifiers, stall and next state.
  always_comb begin
    // NOTE: defaults first so no path through the case leaves a latch.
    state_d     = state_q;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    rd_ready_c  = 1'b0;
    stall_c     = 1'b0;
    misalign_c  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_REQ: begin
        state_d = ST_IDLE;
        if (misaligned) begin
          misalign_c = 1'b1;
        end else if (is_load | is_store) begin
          mem_read_c  = is_load;
          mem_write_c = is_store;
          if (!Mem_Req_Ack) begin
            state_d = ST_REQ;
            stall_c = 1'b1;
          end else if (is_load) begin
            state_d = ST_RD_WAIT;
            stall_c = 1'b1;
          end
        end
      end
      ST_RD_WAIT: begin
        rd_ready_c = 1'b1;
        if (Read_data_Valid) state_d = ST_IDLE;
        else                 stall_c = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Next MEM_WB contents: the instruction on completion, a bubble while stalled.
  always_comb begin
    wb_d = '0;
    if (!stall_c) begin
      wb_d.pc         = EX_MEM_PC;
      wb_d.rd         = EX_MEM_rd;
      wb_d.alu_result = EX_MEM_ALU_Result;
      wb_d.mem2reg    = EX_MEM_Mem2Reg;
      wb_d.reg_write  = EX_MEM_RegWrite & ~misalign_c;
      wb_d.instr      = EX_MEM_Instr;
      wb_d.mem_data   = (state_q == ST_RD_WAIT) ? load_data : 32'd0;
    end
  end

  // State and MEM_WB registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking so every register samples the pre-edge values.
    if (rst) begin
      state_q <= ST_IDLE;
      wb_q    <= '0;
    end else begin
      state_q <= state_d;
      wb_q    <= wb_d;
    end
  end

`ifdef MEM_MISALIGN_CHECK_EN
  logic misalign_q;

  // One-cycle registered flag for a rejected misaligned access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_c;
  end

  assign mem_misalign = misalign_q;
`endif

  // Handshake outputs are forced low while reset is asserted.
  assign Address         = {EX_MEM_ALU_Result[31:2], 2'b00};
  assign MemRead         = mem_read_c & ~rst;
  assign MemWrite        = mem_write_c & ~rst;
  assign Read_data_Ready = rd_ready_c & ~rst;
  assign mem_stall       = stall_c & ~rst;
  assign Write_data      = st_data;
  assign Write_strb      = MemWrite ? st_strb : 4'h0;

  assign MEM_WB_PC         = wb_q.pc;
  assign MEM_WB_rd         = wb_q.rd;
  assign MEM_WB_ALU_Result = wb_q.alu_result;
  assign MEM_WB_Mem2Reg    = wb_q.mem2reg;
  assign MEM_WB_RegWrite   = wb_q.reg_write;
  assign MEM_WB_Instr      = wb_q.instr;
  assign MEM_WB_Mem_Data   = wb_q.mem_data;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed cases followed by
// randomized transactions against an arithmetic reference model.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] EX_MEM_PC, EX_MEM_ALU_Result, EX_MEM_rdata2, EX_MEM_Instr;
  logic [4:0]  EX_MEM_rd;
  logic        EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_RegWrite;
  logic [1:0]  EX_MEM_Mem2Reg;
  logic [31:0] Address, Write_data, Read_data;
  logic        MemRead, MemWrite, Mem_Req_Ack, Read_data_Valid, Read_data_Ready, mem_stall;
  logic [3:0]  Write_strb;
  logic [31:0] MEM_WB_PC, MEM_WB_ALU_Result, MEM_WB_Instr, MEM_WB_Mem_Data;
  logic [4:0]  MEM_WB_rd;
  logic [1:0]  MEM_WB_Mem2Reg;
  logic        MEM_WB_RegWrite;
`ifdef MEM_MISALIGN_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
  logic mem_misalign;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  mem_access_stage dut (
    .clk               (clk),
    .rst               (rst),
    .EX_MEM_PC         (EX_MEM_PC),
    .EX_MEM_rd         (EX_MEM_rd),
    .EX_MEM_ALU_Result (EX_MEM_ALU_Result),
    .EX_MEM_rdata2     (EX_MEM_rdata2),
    .EX_MEM_MemRead    (EX_MEM_MemRead),
    .EX_MEM_MemWrite   (EX_MEM_MemWrite),
    .EX_MEM_Mem2Reg    (EX_MEM_Mem2Reg),
    .EX_MEM_RegWrite   (EX_MEM_RegWrite),
    .EX_MEM_Instr      (EX_MEM_Instr),
    .Address           (Address),
    .MemRead           (MemRead),
    .MemWrite          (MemWrite),
    .Write_data        (Write_data),
    .Write_strb        (Write_strb),
    .Mem_Req_Ack       (Mem_Req_Ack),
    .Read_data         (Read_data),
    .Read_data_Valid   (Read_data_Valid),
    .Read_data_Ready   (Read_data_Ready),
    .mem_stall         (mem_stall),
    .MEM_WB_PC         (MEM_WB_PC),
    .MEM_WB_rd         (MEM_WB_rd),
    .MEM_WB_ALU_Result (MEM_WB_ALU_Result),
    .MEM_WB_Mem2Reg    (MEM_WB_Mem2Reg),
    .MEM_WB_RegWrite   (MEM_WB_RegWrite),
    .MEM_WB_Instr      (MEM_WB_Instr),
    .MEM_WB_Mem_Data   (MEM_WB_Mem_Data)
`ifdef MEM_MISALIGN_CHECK_EN
    ,
    .mem_misalign      (mem_misalign)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: pick the addressed lane by shifting, then extend arithmetically.
  function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] raw);
    logic [31:0] b, h;
    b = (raw >> (8 * a)) & 32'hFF;
    h = (raw >> (16 * (a / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return raw;
    endcase
  endfunction

  task automatic store_model(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] d,
                             output logic [31:0] strb, output logic [31:0] wd);
    case (f3)
      3'd0: begin strb = 32'd1 << a;       wd = {24'd0, d[7:0]} * 32'h0101_0101; end
      3'd1: begin strb = 32'd3 << (a & 2); wd = {16'd0, d[15:0]} * 32'h0001_0001; end
      default: begin strb = 32'hF;         wd = d; end
    endcase
  endtask

  function automatic bit misaligned(input bit ld, input bit st, input logic [2:0] f3,
                                    input logic [1:0] a);
    bit half, word;
    half = ld ? (f3 == 3'd1 || f3 == 3'd5) : (f3 == 3'd1);
    word = ld ? !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5)
              : !(f3 == 3'd0 || f3 == 3'd1);
    return CHECK_EN && (ld || st) && ((half && a[0]) || (word && a != 2'd0));
  endfunction

  task automatic apply(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] wd, input bit ld, input bit st,
                       input logic [1:0] m2r, input bit rw, input logic [2:0] f3);
    EX_MEM_PC         = pc;
    EX_MEM_rd         = rd;
    EX_MEM_ALU_Result = alu;
    EX_MEM_rdata2     = wd;
    EX_MEM_MemRead    = ld;
    EX_MEM_MemWrite   = st;
    EX_MEM_Mem2Reg    = m2r;
    EX_MEM_RegWrite   = rw;
    EX_MEM_Instr      = ($urandom & 32'hFFFF_8FFF) | ({29'd0, f3} << 12);
  endtask

  // Run the applied instruction to completion. Ack arrives ack_dly cycles after
  // issue, load data vld_dly cycles after ack; inject adds a spurious Valid with
  // the ack, which the stage must ignore.
  task automatic run_txn(input int ack_dly, input int vld_dly, input logic [31:0] rdata,
                         input bit inject, input string tag);
    logic [2:0]  f3;
    logic [1:0]  a;
    logic [31:0] e_strb, e_wd, e_md;
    bit          ld, st, mis, done;
    int          stalls, cyc, exp_stalls;
    f3  = EX_MEM_Instr[14:12];
    a   = EX_MEM_ALU_Result[1:0];
    ld  = EX_MEM_MemRead;
    st  = EX_MEM_MemWrite && !EX_MEM_MemRead;
    mis = misaligned(ld, st, f3, a);
    exp_stalls = mis ? 0 : ld ? ack_dly + vld_dly : st ? ack_dly : 0;
    store_model(f3, a, EX_MEM_rdata2, e_strb, e_wd);
    e_md   = (ld && !mis) ? exp_load(f3, a, rdata) : 32'd0;
    stalls = 0;
    done   = 1'b0;
    cyc    = 0;
    while (!done && cyc < 64) begin
      Mem_Req_Ack     = (ld || st) && cyc == ack_dly;
      Read_data_Valid = ld && (cyc == ack_dly + vld_dly || (inject && cyc == ack_dly));
      Read_data       = (cyc == ack_dly + vld_dly) ? rdata : $urandom;
      @(negedge clk);
      if (cyc <= ack_dly || !ld) begin
        check({tag, ".MemRead"}, MemRead, ld && !mis);
        check({tag, ".MemWrite"}, MemWrite, st && !mis);
        check({tag, ".Ready_req"}, Read_data_Ready, 1'b0);
        if ((ld || st) && !mis) check({tag, ".Address"}, Address, EX_MEM_ALU_Result & ~32'd3);
        if (st && !mis) begin
          check({tag, ".Write_strb"}, Write_strb, e_strb);
          check({tag, ".Write_data"}, Write_data, e_wd);
        end
      end else begin
        check({tag, ".Ready_wait"}, Read_data_Ready, 1'b1);
        check({tag, ".MemRead_wait"}, MemRead, 1'b0);
      end
      if (mem_stall) stalls++;
      else done = 1'b1;
      @(posedge clk);
      #1;
      if (!done) begin
        check({tag, ".bubble_RegWrite"}, MEM_WB_RegWrite, 1'b0);
        check({tag, ".bubble_PC"}, MEM_WB_PC, 32'd0);
      end
      cyc++;
    end
    Mem_Req_Ack     = 1'b0;
    Read_data_Valid = 1'b0;
    check({tag, ".completed"}, done, 1'b1);
    check({tag, ".stall_cycles"}, stalls, exp_stalls);
    check({tag, ".WB_PC"}, MEM_WB_PC, EX_MEM_PC);
    check({tag, ".WB_rd"}, MEM_WB_rd, EX_MEM_rd);
    check({tag, ".WB_ALU"}, MEM_WB_ALU_Result, EX_MEM_ALU_Result);
    check({tag, ".WB_Mem2Reg"}, MEM_WB_Mem2Reg, EX_MEM_Mem2Reg);
    check({tag, ".WB_RegWrite"}, MEM_WB_RegWrite, EX_MEM_RegWrite && !mis);
    check({tag, ".WB_Instr"}, MEM_WB_Instr, EX_MEM_Instr);
    check({tag, ".WB_Mem_Data"}, MEM_WB_Mem_Data, e_md);
`ifdef MEM_MISALIGN_CHECK_EN
    check({tag, ".mem_misalign"}, mem_misalign, mis);
`endif
  endtask

  initial begin
    logic [2:0] f3;
    int         kind;
    apply(32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 1'b0, 2'd0, 1'b0, 3'd0);
    EX_MEM_Instr    = 32'd0;
    Mem_Req_Ack     = 1'b0;
    Read_data_Valid = 1'b0;
    Read_data       = 32'd0;

    // Reset state
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst.WB_PC", MEM_WB_PC, 32'd0);
    check("rst.WB_RegWrite", MEM_WB_RegWrite, 1'b0);
    check("rst.WB_Instr", MEM_WB_Instr, 32'd0);
    check("rst.WB_Mem_Data", MEM_WB_Mem_Data, 32'd0);
    check("rst.MemRead", MemRead, 1'b0);
    check("rst.MemWrite", MemWrite, 1'b0);
    check("rst.Ready", Read_data_Ready, 1'b0);
    check("rst.stall", mem_stall, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Plain ALU op: latency 1, never stalls
    apply(32'h100, 5'd5, 32'h1234, 32'd0, 1'b0, 1'b0, 2'd0, 1'b1, 3'd0);
    run_txn(0, 0, 32'd0, 1'b0, "alu");
    // SB at byte lane 3, acked immediately
    apply(32'h104, 5'd0, 32'h103, 32'hAB, 1'b0, 1'b1, 2'd0, 1'b0, 3'd0);
    run_txn(0, 0, 32'd0, 1'b0, "sb");
    // LB lane 2, ack after 2 cycles, data 3 cycles later
    apply(32'h108, 5'd7, 32'h102, 32'd0, 1'b1, 1'b0, 2'd1, 1'b1, 3'd0);
    run_txn(2, 3, 32'h0080_0000, 1'b0, "lb");
    // LHU upper half, then LW of the same word
    apply(32'h10C, 5'd8, 32'h102, 32'd0, 1'b1, 1'b0, 2'd1, 1'b1, 3'd5);
    run_txn(1, 1, 32'hBEEF_0000, 1'b0, "lhu");
    apply(32'h110, 5'd9, 32'h100, 32'd0, 1'b1, 1'b0, 2'd1, 1'b1, 3'd2);
    run_txn(0, 2, 32'hBEEF_0000, 1'b0, "lw");
    // LH with a spurious Valid alongside the ack
    apply(32'h114, 5'd10, 32'h202, 32'd0, 1'b1, 1'b0, 2'd1, 1'b1, 3'd1);
    run_txn(1, 2, 32'h8001_1234, 1'b1, "lh_inject");

    // Reset while waiting for load data
    apply(32'h118, 5'd11, 32'h200, 32'd0, 1'b1, 1'b0, 2'd1, 1'b1, 3'd2);
    Mem_Req_Ack = 1'b1;
    @(negedge clk);
    check("rstmid.MemRead", MemRead, 1'b1);
    @(posedge clk);
    #1 Mem_Req_Ack = 1'b0;
    @(negedge clk);
    check("rstmid.Ready_before", Read_data_Ready, 1'b1);
    check("rstmid.stall_before", mem_stall, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("rstmid.Ready", Read_data_Ready, 1'b0);
    check("rstmid.stall", mem_stall, 1'b0);
    check("rstmid.MemRead_rst", MemRead, 1'b0);
    check("rstmid.WB_RegWrite", MEM_WB_RegWrite, 1'b0);
    check("rstmid.WB_Mem_Data", MEM_WB_Mem_Data, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    apply(32'h11C, 5'd12, 32'h5A5A, 32'd0, 1'b0, 1'b0, 2'd0, 1'b1, 3'd0);
    Read_data_Valid = 1'b1;
    Read_data       = 32'hDEAD_BEEF;
    @(negedge clk);
    check("late_valid.Ready", Read_data_Ready, 1'b0);
    check("late_valid.stall", mem_stall, 1'b0);
    @(posedge clk);
    #1;
    Read_data_Valid = 1'b0;
    check("late_valid.WB_ALU", MEM_WB_ALU_Result, 32'h5A5A);
    check("late_valid.WB_Mem_Data", MEM_WB_Mem_Data, 32'd0);
    check("late_valid.WB_RegWrite", MEM_WB_RegWrite, 1'b1);

`ifdef MEM_MISALIGN_CHECK_EN
    // Misaligned word load is rejected without a request
    apply(32'h120, 5'd13, 32'h101, 32'd0, 1'b1, 1'b0, 2'd1, 1'b1, 3'd2);
    run_txn(0, 1, 32'h1111_2222, 1'b0, "lw_misalign");
`endif

    // Randomized mix of ALU ops, loads and stores
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      f3   = (kind == 2) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
      apply($urandom, 5'($urandom), $urandom, $urandom, kind == 1, kind == 2,
            2'($urandom), 1'($urandom), f3);
      run_txn($urandom_range(0, 3), $urandom_range(1, 3), $urandom,
              1'($urandom_range(0, 1)), "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
